// File: rtl/mem_arbiter.sv
// Two-requester (cpu/dma) memory bus arbiter: IDLE -> ACCESS (WAIT_CYCLES) -> DONE, all outputs registered.
// Round-robin on ties by default; define ARB_FIXED_PRIORITY_EN to make cpu always win ties.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_data_in,
    input  logic [1:0]  cpu_write_mask,
    input  logic        cpu_write_enable,
    output logic [15:0] cpu_data_out,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic [15:0] dma_address,
    input  logic [15:0] dma_data_in,
    input  logic [1:0]  dma_write_mask,
    input  logic        dma_write_enable,
    output logic [15:0] dma_data_out,
    output logic        dma_ack,
    output logic [15:0] mem_address,
    output logic [15:0] mem_data_in,
    output logic [1:0]  mem_write_mask,
    output logic        mem_bus_enable,
    output logic        mem_write_enable,
    input  logic [15:0] mem_data_out,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        gnt_dma, gnt_dma_nxt;
    logic        cur_we, cur_we_nxt;
    logic        pick_dma;
    logic [15:0] cpu_data_out_nxt, dma_data_out_nxt;
    logic        cpu_ack_nxt, dma_ack_nxt;
    logic [15:0] mem_address_nxt, mem_data_in_nxt;
    logic [1:0]  mem_write_mask_nxt;
    logic        mem_bus_enable_nxt, mem_write_enable_nxt, busy_nxt;

`ifdef ARB_FIXED_PRIORITY_EN
    assign pick_dma = dma_req & ~cpu_req;
`else
    // last_dma resets high so the very first tie goes to cpu
    logic last_dma, last_dma_nxt;
    assign pick_dma = dma_req & (~cpu_req | ~last_dma);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_dma <= 1'b1;
        else       last_dma <= last_dma_nxt;
    end
`endif

    always_comb begin
        state_nxt            = state;
        cnt_nxt              = cnt;
        gnt_dma_nxt          = gnt_dma;
        cur_we_nxt           = cur_we;
        cpu_data_out_nxt     = cpu_data_out;
        dma_data_out_nxt     = dma_data_out;
        cpu_ack_nxt          = 1'b0;
        dma_ack_nxt          = 1'b0;
        mem_address_nxt      = mem_address;
        mem_data_in_nxt      = mem_data_in;
        mem_write_mask_nxt   = mem_write_mask;
        mem_bus_enable_nxt   = 1'b0;
        mem_write_enable_nxt = 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
        last_dma_nxt         = last_dma;
`endif
        case (state)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    state_nxt            = ACCESS;
                    gnt_dma_nxt          = pick_dma;
                    cnt_nxt              = 4'(WAIT_CYCLES - 1);
                    mem_bus_enable_nxt   = 1'b1;
                    mem_address_nxt      = pick_dma ? dma_address      : cpu_address;
                    mem_data_in_nxt      = pick_dma ? dma_data_in      : cpu_data_in;
                    mem_write_mask_nxt   = pick_dma ? dma_write_mask   : cpu_write_mask;
                    cur_we_nxt           = pick_dma ? dma_write_enable : cpu_write_enable;
                    // the single write strobe lands on the first ACCESS cycle
                    mem_write_enable_nxt = cur_we_nxt;
`ifndef ARB_FIXED_PRIORITY_EN
                    last_dma_nxt         = pick_dma;
`endif
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                    if (gnt_dma) dma_ack_nxt = 1'b1;
                    else         cpu_ack_nxt = 1'b1;
                    if (!cur_we) begin
                        if (gnt_dma) dma_data_out_nxt = mem_data_out;
                        else         cpu_data_out_nxt = mem_data_out;
                    end
                end else begin
                    cnt_nxt            = cnt - 4'd1;
                    mem_bus_enable_nxt = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= 4'd0;
            gnt_dma          <= 1'b0;
            cur_we           <= 1'b0;
            cpu_data_out     <= 16'd0;
            dma_data_out     <= 16'd0;
            cpu_ack          <= 1'b0;
            dma_ack          <= 1'b0;
            mem_address      <= 16'd0;
            mem_data_in      <= 16'd0;
            mem_write_mask   <= 2'd0;
            mem_bus_enable   <= 1'b0;
            mem_write_enable <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            gnt_dma          <= gnt_dma_nxt;
            cur_we           <= cur_we_nxt;
            cpu_data_out     <= cpu_data_out_nxt;
            dma_data_out     <= dma_data_out_nxt;
            cpu_ack          <= cpu_ack_nxt;
            dma_ack          <= dma_ack_nxt;
            mem_address      <= mem_address_nxt;
            mem_data_in      <= mem_data_in_nxt;
            mem_write_mask   <= mem_write_mask_nxt;
            mem_bus_enable   <= mem_bus_enable_nxt;
            mem_write_enable <= mem_write_enable_nxt;
            busy             <= busy_nxt;
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: ACCESS cycles per transaction; legal range 1..15.
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports cpu_req / dma_req  input  1  transaction request, held until the matching ack.
REQ-005 SHALL have ports cpu_address / dma_address  input  16  word address.
REQ-006 SHALL have ports cpu_data_in / dma_data_in  input  16  write data.
REQ-007 SHALL have ports cpu_write_mask / dma_write_mask  input  2  byte-lane mask.
REQ-008 SHALL have ports cpu_write_enable / dma_write_enable  input  1  1=write, 0=read.
REQ-009 SHALL have ports cpu_data_out / dma_data_out  output  16  registered read data.
REQ-010 SHALL have ports cpu_ack / dma_ack  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports mem_address  output  16, mem_data_in  output  16 and mem_write_mask  output  2, all driven toward the memory bus.
REQ-012 SHALL have ports mem_bus_enable  output  1 and mem_write_enable  output  1, both driven toward the memory bus.
REQ-013 SHALL have port mem_data_out  input  16  read data returned from the memory bus.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, ACCESS and DONE; all outputs SHALL be registered.
REQ-016 IDLE: with no request, SHALL remain in IDLE and drive mem_bus_enable=0 and mem_write_enable=0.
REQ-017 IDLE: when any req is high, SHALL select a grantee per REQ-022, latch its address, data, mask and write_enable onto the mem_* outputs, load counter=WAIT_CYCLES-1, and enter ACCESS.
REQ-018 ACCESS: mem_bus_enable SHALL be 1 on every cycle; mem_write_enable SHALL be 1 only on the first ACCESS cycle, and only for a write, so peripherals see exactly one write strobe.
REQ-019 ACCESS: on the cycle counter==0, SHALL capture mem_data_out into the grantee's data_out (reads only) and enter DONE; otherwise it SHALL decrement the counter.
REQ-020 DONE: SHALL pulse the grantee's ack for exactly one cycle, drive mem_bus_enable=0, and return to IDLE.
REQ-021 Latency: a request sampled in IDLE at edge N SHALL produce its ack high during cycle N+WAIT_CYCLES+1; throughput SHALL be one transaction per WAIT_CYCLES+2 cycles.
REQ-022 Arbitration: when both reqs are high in IDLE, the grant SHALL go to the requester not granted last (round-robin); a single requester SHALL always win.
REQ-023 A requester SHALL drop req before the edge ending its ack cycle; a req still high in IDLE SHALL be treated as a new transaction.
REQ-024 Request-input changes during ACCESS or DONE SHALL NOT affect the transaction in flight.
REQ-025 A non-granted data_out SHALL hold its value; a write SHALL NOT modify data_out.
REQ-026 When WAIT_CYCLES=1, ACCESS SHALL last exactly one cycle, and that cycle SHALL carry the write strobe and the read capture.

Reset
REQ-027 While reset is high: state SHALL be IDLE, all outputs SHALL be 0, and the counter SHALL be 0.
REQ-028 While reset is high, the round-robin pointer SHALL be "last=dma", so that cpu wins the first tie.
REQ-029 A reset asserted mid-transaction SHALL abort it with no ack issued, and mem_write_enable SHALL drop asynchronously.

Configuration
REQ-030 With macro ARB_FIXED_PRIORITY_EN defined, cpu SHALL always win ties and the round-robin pointer SHALL be removed.
REQ-031 Without ARB_FIXED_PRIORITY_EN, arbitration SHALL be round-robin per REQ-022.

Verification
REQ-032 cpu read 0x8004 (memory returns 0x1234), WAIT_CYCLES=2 -> cpu_ack high exactly cycle N+3, cpu_data_out=0x1234.
REQ-033 dma write 0x4000 data 0x00A5 mask 2'b11 -> mem_write_enable high for exactly one cycle, dma_ack one pulse, dma_data_out unchanged.
REQ-034 cpu_req and dma_req held high for four transactions -> grants alternate cpu, dma, cpu, dma; with ARB_FIXED_PRIORITY_EN, all four go to cpu.
REQ-035 reset pulsed during the second ACCESS cycle of a write -> no ack, all outputs 0, next tie granted to cpu.
REQ-036 WAIT_CYCLES=1, back-to-back cpu reads -> ack every 3 cycles, busy low for one cycle between transactions.
